// File: rtl/seg7_multi_disp.sv
// ---------------------------------------------------------------------------
// seg7_multi_disp
//
// Multi-digit seven-segment display driver. Converts an unsigned binary value
// into DIGITS active-low glyphs, either as hexadecimal nibbles (one-cycle
// encode) or as decimal digits produced by a sequential double-dabble
// converter (one shift-add-3 step per clock). Supports leading-zero blanking
// and an overflow indication when the value does not fit in DIGITS digits.
//
// Parameters:
//   IN_WIDTH  width of the binary input value (4..32)
//   DIGITS    number of seven-segment digits driven (1..8)
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst_n     synchronous reset, active-low
//   load      capture value/hex_mode/blank_lz (accepted only when busy=0)
//   value     unsigned binary value to display
//   hex_mode  1 = hexadecimal digits, 0 = decimal digits
//   blank_lz  1 = blank leading zero digits
//   busy      conversion in progress
//   done      one-cycle pulse: seg/overflow updated this cycle
//   overflow  value does not fit in DIGITS digits (held until next done)
//   seg       active-low segments, digit i at seg[7i+6:7i] (gfedcba),
//             digit 0 least significant
// ---------------------------------------------------------------------------
module seg7_multi_disp #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [IN_WIDTH-1:0]   value,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  // Number of decimal digits needed to hold 2^w-1.
  function automatic int calc_bcd_digits(input int w);
    longint unsigned m;
    int              n;
    m = (64'd1 << w) - 64'd1;
    n = 0;
    while (m != 64'd0) begin
      n = n + 1;
      m = m / 64'd10;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  localparam int BCD_DIGITS = calc_bcd_digits(IN_WIDTH);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(IN_WIDTH);
  localparam int EXT_W      = 64;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(IN_WIDTH - 1);
  localparam logic [6:0]       GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0]       GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ENC
  } state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] val_q;
  logic                hex_q;
  logic                blank_q;
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    cnt;

  logic [EXT_W-1:0]    enc_src;
  logic                enc_ovf;
  logic [7*DIGITS-1:0] enc_seg;
  logic                lead;
  logic [3:0]          nib;

  // Active-low gfedcba pattern for a single hex/decimal digit.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  // so that the following doubling carries correctly into the next decade.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Digit source for the encoder, widened so overflow detection is a single
  // "anything nonzero above the displayed digits" test in both modes.
  always_comb begin
    enc_src = '0;
    if (hex_q) begin
      enc_src = EXT_W'(val_q);
    end else begin
      enc_src = EXT_W'(bcd);
    end
  end

  assign enc_ovf = |(enc_src >> (4 * DIGITS));

  // Walk digits from most to least significant; 'lead' stays set while all
  // digits seen so far are zero, which is exactly the set that gets blanked.
  // Digit 0 is always shown so a zero value still displays "0".
  always_comb begin
    enc_seg = '1;
    lead    = 1'b1;
    nib     = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = enc_src[4*i +: 4];
      if (nib != 4'd0) begin
        lead = 1'b0;
      end
      if (enc_ovf) begin
        enc_seg[7*i +: 7] = GLYPH_DASH;
      end else if (blank_q && lead && (i != 0)) begin
        enc_seg[7*i +: 7] = GLYPH_BLANK;
      end else begin
        enc_seg[7*i +: 7] = glyph(nib);
      end
    end
  end

  // Control FSM with registered outputs. In decimal mode val_q doubles as the
  // shift register feeding the BCD accumulator MSB first; in hex mode it is
  // left untouched and encoded directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      seg      <= '1;
      val_q    <= '0;
      hex_q    <= 1'b0;
      blank_q  <= 1'b0;
      bcd      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            val_q   <= value;
            hex_q   <= hex_mode;
            blank_q <= blank_lz;
            bcd     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= hex_mode ? ENC : CONV;
          end
        end
        CONV: begin
          bcd   <= BCD_W'({add3(bcd), val_q[IN_WIDTH-1]});
          val_q <= {val_q[IN_WIDTH-2:0], 1'b0};
          if (cnt == LAST_STEP) begin
            state <= ENC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ENC: begin
          seg      <= enc_seg;
          overflow <= enc_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_multi_disp.sv
// ---------------------------------------------------------------------------
// tb_seg7_multi_disp
//
// Self-checking bench for seg7_multi_disp. Three instances are exercised:
//   u0: IN_WIDTH=8,  DIGITS=3
//   u1: IN_WIDTH=8,  DIGITS=2
//   u2: IN_WIDTH=12, DIGITS=2
// A transaction-level model predicts busy/done/overflow/seg from the value
// using plain division and powers of the base, and is compared against every
// instance on every falling edge. Directed tests add literal expectations.
// ---------------------------------------------------------------------------
module tb_seg7_multi_disp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        load0, hex0, blank0;
  logic [7:0]  value0;
  logic        busy0, done0, ovf0;
  logic [20:0] seg0;

  logic        load1, hex1, blank1;
  logic [7:0]  value1;
  logic        busy1, done1, ovf1;
  logic [13:0] seg1;

  logic        load2, hex2, blank2;
  logic [11:0] value2;
  logic        busy2, done2, ovf2;
  logic [13:0] seg2;

  seg7_multi_disp #(.IN_WIDTH(8), .DIGITS(3)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load0), .value(value0),
    .hex_mode(hex0), .blank_lz(blank0), .busy(busy0), .done(done0),
    .overflow(ovf0), .seg(seg0)
  );

  seg7_multi_disp #(.IN_WIDTH(8), .DIGITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .value(value1),
    .hex_mode(hex1), .blank_lz(blank1), .busy(busy1), .done(done1),
    .overflow(ovf1), .seg(seg1)
  );

  seg7_multi_disp #(.IN_WIDTH(12), .DIGITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .value(value2),
    .hex_mode(hex2), .blank_lz(blank2), .busy(busy2), .done(done2),
    .overflow(ovf2), .seg(seg2)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state, one entry per instance.
  int              rem   [3];
  bit              mbusy [3];
  bit              mdone [3];
  bit              movf  [3];
  logic [63:0]     mseg  [3];
  longint unsigned cv    [3];
  bit              ch    [3];
  bit              cb    [3];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] g;
    case (d)
      0:       g = 7'b1000000;
      1:       g = 7'b1111001;
      2:       g = 7'b0100100;
      3:       g = 7'b0110000;
      4:       g = 7'b0011001;
      5:       g = 7'b0010010;
      6:       g = 7'b0000010;
      7:       g = 7'b1111000;
      8:       g = 7'b0000000;
      9:       g = 7'b0010000;
      10:      g = 7'b0001000;
      11:      g = 7'b0000011;
      12:      g = 7'b1000110;
      13:      g = 7'b0100001;
      14:      g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  function automatic longint unsigned pow_u(input longint unsigned base, input int n);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * base;
    return p;
  endfunction

  function automatic bit model_ovf(input longint unsigned v, input bit hx, input int nd);
    return v >= pow_u(hx ? 64'd16 : 64'd10, nd);
  endfunction

  // Digit d shows (v / base^d) % base; it is blank when v < base^d, meaning
  // no nonzero digit exists at or above position d.
  function automatic logic [63:0] model_seg(input longint unsigned v, input bit hx,
                                            input bit bl, input int nd);
    longint unsigned base;
    longint unsigned p;
    logic [63:0]     s;
    logic [6:0]      g;
    bit              ov;
    base = hx ? 64'd16 : 64'd10;
    p    = 1;
    s    = '0;
    ov   = model_ovf(v, hx, nd);
    for (int d = 0; d < nd; d++) begin
      if (ov) g = 7'b0111111;
      else if (bl && d > 0 && v < p) g = 7'b1111111;
      else g = glyph(int'((v / p) % base));
      s[7*d +: 7] = g;
      p = p * base;
    end
    return s;
  endfunction

  task automatic model_step(input int i, input bit rst, input bit ld, input longint unsigned v,
                            input bit hx, input bit bl, input int nd, input int w);
    if (!rst) begin
      rem[i]   = 0;
      mbusy[i] = 1'b0;
      mdone[i] = 1'b0;
      movf[i]  = 1'b0;
      mseg[i]  = (64'd1 << (7 * nd)) - 64'd1;
    end else begin
      mdone[i] = 1'b0;
      if (mbusy[i]) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 0) begin
          mbusy[i] = 1'b0;
          mdone[i] = 1'b1;
          movf[i]  = model_ovf(cv[i], ch[i], nd);
          mseg[i]  = model_seg(cv[i], ch[i], cb[i], nd);
        end
      end else if (ld) begin
        mbusy[i] = 1'b1;
        rem[i]   = hx ? 1 : w + 1;
        cv[i]    = v;
        ch[i]    = hx;
        cb[i]    = bl;
      end
    end
  endtask

  // Model advances on the same edge the DUT samples its (stable) inputs.
  always @(posedge clk) begin
    model_step(0, rst_n, load0, 64'(value0), hex0, blank0, 3, 8);
    model_step(1, rst_n, load1, 64'(value1), hex1, blank1, 2, 8);
    model_step(2, rst_n, load2, 64'(value2), hex2, blank2, 2, 12);
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("u0.busy", 64'(busy0), 64'(mbusy[0]));
      check_output("u0.done", 64'(done0), 64'(mdone[0]));
      check_output("u0.overflow", 64'(ovf0), 64'(movf[0]));
      check_output("u0.seg", 64'(seg0), mseg[0]);
      check_output("u1.busy", 64'(busy1), 64'(mbusy[1]));
      check_output("u1.done", 64'(done1), 64'(mdone[1]));
      check_output("u1.overflow", 64'(ovf1), 64'(movf[1]));
      check_output("u1.seg", 64'(seg1), mseg[1]);
      check_output("u2.busy", 64'(busy2), 64'(mbusy[2]));
      check_output("u2.done", 64'(done2), 64'(mdone[2]));
      check_output("u2.overflow", 64'(ovf2), 64'(movf[2]));
      check_output("u2.seg", 64'(seg2), mseg[2]);
    end
  end

  function automatic bit get_done(input int inst);
    case (inst)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic drive_inst(input int inst, input bit ld, input logic [31:0] v,
                            input bit hx, input bit bl);
    case (inst)
      0: begin load0 = ld; value0 = v[7:0];  hex0 = hx; blank0 = bl; end
      1: begin load1 = ld; value1 = v[7:0];  hex1 = hx; blank1 = bl; end
      default: begin load2 = ld; value2 = v[11:0]; hex2 = hx; blank2 = bl; end
    endcase
  endtask

  // Called on a falling edge; returns the number of rising edges between the
  // load-sampling edge and the edge that raised done.
  task automatic wait_done(input int inst, output int lat);
    lat = 0;
    while (!get_done(inst) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!get_done(inst)) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: done never seen on instance %0d, waited %0d cycles", inst, lat);
    end
  endtask

  task automatic apply_stimulus(input int inst, input logic [31:0] v, input bit hx,
                                input bit bl, output int lat);
    drive_inst(inst, 1'b1, v, hx, bl);
    @(negedge clk);
    drive_inst(inst, 1'b0, v, hx, bl);
    wait_done(inst, lat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int dcount;
    rst_n = 1'b0;
    drive_inst(0, 1'b0, 0, 1'b0, 1'b0);
    drive_inst(1, 1'b0, 0, 1'b0, 1'b0);
    drive_inst(2, 1'b0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_en = 1'b1;

    $display("[TB] reset state");
    check_output("rst_seg0", 64'(seg0), 64'h1FFFFF);
    check_output("rst_busy0", 64'(busy0), 64'd0);
    check_output("rst_done0", 64'(done0), 64'd0);
    check_output("rst_ovf0", 64'(ovf0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] decimal and hex conversions, 3 digits");
    apply_stimulus(0, 255, 1'b0, 1'b0, lat);
    check_output("dec255_latency", 64'(lat), 64'd9);
    check_output("dec255_seg", 64'(seg0), 64'({7'b0100100, 7'b0010010, 7'b0010010}));
    check_output("dec255_ovf", 64'(ovf0), 64'd0);

    apply_stimulus(0, 8'hAF, 1'b1, 1'b1, lat);
    check_output("hexAF_latency", 64'(lat), 64'd1);
    check_output("hexAF_seg", 64'(seg0), 64'({7'b1111111, 7'b0001000, 7'b0001110}));

    apply_stimulus(0, 7, 1'b0, 1'b1, lat);
    check_output("dec7_blank_seg", 64'(seg0), 64'({7'b1111111, 7'b1111111, 7'b1111000}));
    apply_stimulus(0, 7, 1'b0, 1'b0, lat);
    check_output("dec7_noblank_seg", 64'(seg0), 64'({7'b1000000, 7'b1000000, 7'b1111000}));
    apply_stimulus(0, 0, 1'b0, 1'b1, lat);
    check_output("dec0_blank_seg", 64'(seg0), 64'({7'b1111111, 7'b1111111, 7'b1000000}));

    $display("[TB] overflow boundaries, 2 digits");
    apply_stimulus(1, 100, 1'b0, 1'b0, lat);
    check_output("dec100_ovf", 64'(ovf1), 64'd1);
    check_output("dec100_seg", 64'(seg1), 64'({7'b0111111, 7'b0111111}));
    apply_stimulus(1, 99, 1'b0, 1'b1, lat);
    check_output("dec99_ovf", 64'(ovf1), 64'd0);
    check_output("dec99_seg", 64'(seg1), 64'({7'b0010000, 7'b0010000}));
    apply_stimulus(1, 8'hFF, 1'b1, 1'b0, lat);
    check_output("hexFF_ovf", 64'(ovf1), 64'd0);
    check_output("hexFF_seg", 64'(seg1), 64'({7'b0001110, 7'b0001110}));

    apply_stimulus(2, 12'h100, 1'b1, 1'b0, lat);
    check_output("hex100_ovf", 64'(ovf2), 64'd1);
    check_output("hex100_seg", 64'(seg2), 64'({7'b0111111, 7'b0111111}));
    apply_stimulus(2, 12'h0AB, 1'b1, 1'b1, lat);
    check_output("hex0AB_seg", 64'(seg2), 64'({7'b0001000, 7'b0000011}));
    apply_stimulus(2, 999, 1'b0, 1'b1, lat);
    check_output("dec999_w12_latency", 64'(lat), 64'd13);
    check_output("dec999_w12_ovf", 64'(ovf2), 64'd1);

    $display("[TB] load while busy is ignored");
    drive_inst(0, 1'b1, 123, 1'b0, 1'b0);
    @(negedge clk);
    drive_inst(0, 1'b0, 123, 1'b0, 1'b0);
    @(negedge clk);
    drive_inst(0, 1'b1, 45, 1'b1, 1'b0);
    @(negedge clk);
    drive_inst(0, 1'b0, 45, 1'b1, 1'b0);
    @(negedge clk);
    drive_inst(0, 1'b1, 45, 1'b1, 1'b0);
    @(negedge clk);
    drive_inst(0, 1'b0, 45, 1'b1, 1'b0);
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      if (done0) dcount++;
      @(negedge clk);
    end
    check_output("ignore_done_count", 64'(dcount), 64'd1);
    check_output("ignore_seg", 64'(seg0), 64'({7'b1111001, 7'b0100100, 7'b0110000}));

    $display("[TB] load held high through done");
    drive_inst(0, 1'b1, 42, 1'b0, 1'b0);
    @(negedge clk);
    wait_done(0, lat);
    check_output("held_first_latency", 64'(lat), 64'd9);
    check_output("held_busy_at_done", 64'(busy0), 64'd0);
    @(negedge clk);
    check_output("held_busy_after_done", 64'(busy0), 64'd1);
    drive_inst(0, 1'b0, 42, 1'b0, 1'b0);
    wait_done(0, lat);
    check_output("held_second_latency", 64'(lat), 64'd9);
    check_output("held_seg", 64'(seg0), 64'({7'b1000000, 7'b0011001, 7'b0100100}));

    $display("[TB] reset during conversion");
    drive_inst(0, 1'b1, 200, 1'b0, 1'b0);
    @(negedge clk);
    drive_inst(0, 1'b0, 200, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("abort_busy", 64'(busy0), 64'd0);
    check_output("abort_done", 64'(done0), 64'd0);
    check_output("abort_seg", 64'(seg0), 64'h1FFFFF);
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    check_output("abort_no_done", 64'(dcount), 64'd0);
    apply_stimulus(0, 56, 1'b0, 1'b1, lat);
    check_output("after_abort_latency", 64'(lat), 64'd9);
    check_output("after_abort_seg", 64'(seg0), 64'({7'b1111111, 7'b0010010, 7'b0000010}));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_multi_disp.md
Name: seg7_multi_disp

Overview:
- Parametrised multi-digit seven-segment display driver.
- Converts an unsigned binary value to DIGITS glyphs, in either hexadecimal or decimal mode.
- Decimal conversion is sequential: one shift-add-3 (double-dabble) step per clock.
- Adds leading-zero blanking, overflow indication and a load/busy/done handshake.
- Sits between datapath result registers and the board HEX displays.

Parameters:
IN_WIDTH, 8, width of the binary input value (min 4, max 32).
DIGITS, 3, number of seven-segment digits driven (min 1, max 8).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
load  in  1  request: capture value/hex_mode/blank_lz (accepted only when busy=0)
value  in  IN_WIDTH  unsigned binary value to display
hex_mode  in  1  1=hexadecimal digits, 0=decimal digits
blank_lz  in  1  1=blank leading zero digits
busy  out  1  conversion in progress
done  out  1  one-cycle pulse: seg/overflow updated this cycle
overflow  out  1  value does not fit in DIGITS digits (held until next done)
seg  out  7*DIGITS  active-low segments; digit i occupies seg[7i+6:7i] (gfedcba), digit 0 least significant

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, overflow=0, all seg bits 1 (all blank). Reset overrides load and aborts any conversion in progress; no done pulse is produced.
- Internal BCD register is 4*BCD_DIGITS bits, where BCD_DIGITS = number of decimal digits of 2^IN_WIDTH-1 (localparam).
- IDLE:
  - busy=0.
  - load=1: latch value, hex_mode and blank_lz; clear the BCD register and the step counter; busy=1.
  - Next state is ENC if hex_mode=1, otherwise CONV.
  - load=0: stay in IDLE.
- CONV:
  - Each cycle: every BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1.
  - Exactly IN_WIDTH cycles, then go to ENC.
- ENC (one cycle):
  - Compute digits. Hex: nibbles of the latched value. Decimal: BCD nibbles.
  - Register seg and overflow; done=1 for this cycle only; busy=0; return to IDLE.
- Latency: done is asserted N edges after the edge that sampled load, with N=1 in hex mode and N=IN_WIDTH+1 in decimal mode.
- busy=1 from the sampling edge up to, but not including, the done cycle.
- load while busy=1 is ignored (not queued).
- load in the done cycle is accepted (back-to-back operation).
- seg and overflow change only in the done cycle; between conversions they hold their last value.
- Overflow:
  - Hex: any value bit at position >=4*DIGITS is set.
  - Decimal: any BCD digit at index >=DIGITS is nonzero.
  - On overflow every digit shows dash 0111111 and overflow=1; this takes priority over blanking.
- Glyphs (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank=1111111.
- Leading-zero blanking (blank_lz=1): every digit above the most significant nonzero digit is blank. Digit 0 is never blanked, so value 0 shows "0".
- Decimal nibbles are always 0-9; A-F can appear only in hex mode.

Test Plan:
- Defaults, decimal, value=255, blank_lz=0:
  - done exactly 9 edges after load.
  - seg[20:14]=0100100, seg[13:7]=0010010, seg[6:0]=0010010, overflow=0.
- Defaults, hex, value=8'hAF, blank_lz=1:
  - done 1 edge after load.
  - digit2=1111111, digit1=0001000, digit0=0001110.
- Defaults, decimal, value=7:
  - blank_lz=1 -> 1111111,1111111,1111000.
  - blank_lz=0 -> 1000000,1000000,1111000.
  - value=0 with blank_lz=1 -> digit0=1000000, digits 2 and 1 blank.
- DIGITS=2:
  - decimal 100 -> overflow=1, both digits 0111111.
  - decimal 99 -> overflow=0, 0010000,0010000.
  - hex 8'hFF -> no overflow.
  - IN_WIDTH=12 instance, hex 12'h100 -> overflow=1.
- Handshake:
  - load pulsed at cycles 2 and 4 of a decimal conversion -> ignored, single done.
  - load held high through done -> second conversion starts immediately, busy drops for the done cycle only.
- rst_n=0 for one edge at CONV step 3 -> busy=0, seg all 1, no done. A fresh load afterwards completes normally.
